// File: rtl/shifter_pkg.sv
// rtl/shifter_pkg.sv - shared command codes, state/direction types and one-bit shift step
package shifter_pkg;

  // Width the shift_step helper operates on; the shifter's WIDTH must match it.
  localparam int DATA_W = 32;

  localparam logic [2:0] CMD_NOP  = 3'b000;
  localparam logic [2:0] CMD_LOAD = 3'b001;
  localparam logic [2:0] CMD_SLL  = 3'b010;
  localparam logic [2:0] CMD_SRL  = 3'b011;
  localparam logic [2:0] CMD_SRA  = 3'b100;

  typedef enum logic {
    IDLE  = 1'b0,
    SHIFT = 1'b1
  } state_e;

  typedef enum logic [1:0] {
    DIR_SLL = 2'd0,
    DIR_SRL = 2'd1,
    DIR_SRA = 2'd2
  } dir_e;

  // One iteration of the shifter: move every bit by one position.
  function automatic logic [DATA_W-1:0] shift_step(input dir_e dir,
                                                   input logic [DATA_W-1:0] value);
    logic [DATA_W-1:0] res;
    res = value;
    case (dir)
      DIR_SLL: res = {value[DATA_W-2:0], 1'b0};
      DIR_SRL: res = {1'b0, value[DATA_W-1:1]};
      DIR_SRA: res = {value[DATA_W-1], value[DATA_W-1:1]};
      default: res = value;
    endcase
    return res;
  endfunction

endpackage

// File: rtl/iter_shifter_if.sv
// rtl/iter_shifter_if.sv - command/result bundle between ALU control and the shifter
interface iter_shifter_if #(
  parameter int WIDTH   = 32,
  parameter int SHAMT_W = 5
);
  logic [2:0]         cmd;
  logic [SHAMT_W-1:0] shamt;
  logic [WIDTH-1:0]   data_in;
  logic [WIDTH-1:0]   data_out;
  logic               busy;
  logic               done;

  modport master (
    output cmd, shamt, data_in,
    input  data_out, busy, done
  );

  modport slave (
    input  cmd, shamt, data_in,
    output data_out, busy, done
  );
endinterface

// File: rtl/iter_shifter.sv
// rtl/iter_shifter.sv - iterative one-bit-per-cycle 32-bit shift unit with busy/done handshake
module iter_shifter
  import shifter_pkg::*;
#(
  parameter int WIDTH   = DATA_W,
  parameter int SHAMT_W = 5
) (
  input  logic           clk,
  input  logic           reset,
  iter_shifter_if.slave  bus
);

  state_e             state_q, state_d;
  dir_e               dir_q, dir_d;
  logic [SHAMT_W-1:0] cnt_q, cnt_d;
  logic [WIDTH-1:0]   data_q, data_d;
  logic               done_q, done_d;

  // State register; reset wins over everything, including an in-flight shift.
  always_ff @(posedge clk) begin
    if (reset) begin
      state_q <= IDLE;
      dir_q   <= DIR_SLL;
      cnt_q   <= '0;
      data_q  <= '0;
      done_q  <= 1'b0;
    end else begin
      state_q <= state_d;
      dir_q   <= dir_d;
      cnt_q   <= cnt_d;
      data_q  <= data_d;
      done_q  <= done_d;
    end
  end

  // Next-state: accept commands only in IDLE (which includes the done cycle),
  // otherwise step once per cycle until the count runs out.
  always_comb begin
    state_d = state_q;
    dir_d   = dir_q;
    cnt_d   = cnt_q;
    data_d  = data_q;
    done_d  = 1'b0;
    case (state_q)
      IDLE: begin
        case (bus.cmd)
          CMD_LOAD: data_d = bus.data_in;
          CMD_SLL, CMD_SRL, CMD_SRA: begin
            case (bus.cmd)
              CMD_SRL: dir_d = DIR_SRL;
              CMD_SRA: dir_d = DIR_SRA;
              default: dir_d = DIR_SLL;
            endcase
            cnt_d = bus.shamt;
            // A zero-length shift completes immediately without ever raising busy.
            if (bus.shamt == '0) begin
              done_d = 1'b1;
            end else begin
              state_d = SHIFT;
            end
          end
          default: ; // NOP and reserved codes leave everything untouched
        endcase
      end
      SHIFT: begin
        data_d = shift_step(dir_q, data_q);
        cnt_d  = cnt_q - SHAMT_W'(1);
        if (cnt_q == SHAMT_W'(1)) begin
          state_d = IDLE;
          done_d  = 1'b1;
        end
      end
      default: state_d = IDLE;
    endcase
  end

  assign bus.data_out = data_q;
  assign bus.busy     = (state_q == SHIFT);
  assign bus.done     = done_q;

endmodule

// File: tb/tb_iter_shifter.sv
// tb/tb_iter_shifter.sv - scoreboard bench for iter_shifter
module tb_iter_shifter;
  import shifter_pkg::*;

  logic clk = 1'b0;
  logic reset = 1'b1;
  always #5 clk = ~clk;

  iter_shifter_if #(.WIDTH(32), .SHAMT_W(5)) bus ();

  iter_shifter #(.WIDTH(32), .SHAMT_W(5)) dut (
    .clk   (clk),
    .reset (reset),
    .bus   (bus)
  );

  typedef struct {
    logic [31:0] data;
    int          busy_cycles;
  } exp_t;

  exp_t exp_q[$];
  int   checks = 0;
  int   errors = 0;
  int   busy_run = 0;

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] req);
    checks++;
    if (act !== req) begin
      errors++;
      $display("FAIL %s actual=%h required=%h", name, act, req);
    end
  endtask

  // Monitor: count busy cycles of each shift and score the result on every done.
  always @(negedge clk) begin
    if (bus.busy === 1'b1 && bus.done === 1'b1) begin
      checks++;
      errors++;
      $display("FAIL busy_and_done actual=11 required=not both");
    end
    if (bus.busy === 1'b1) begin
      busy_run++;
    end else if (bus.done === 1'b1) begin
      if (exp_q.size() == 0) begin
        checks++;
        errors++;
        $display("FAIL unexpected_done actual=%h required=no done", bus.data_out);
      end else begin
        exp_t e;
        e = exp_q.pop_front();
        check("done_data", bus.data_out, e.data);
        check("busy_cycles", 32'(busy_run), 32'(e.busy_cycles));
      end
      busy_run = 0;
    end else begin
      busy_run = 0;
    end
  end

  // Present one command at a negedge; it is sampled at the next posedge. Ends at a negedge.
  task automatic send(input logic [2:0] c, input logic [4:0] s, input logic [31:0] d);
    bus.cmd     = c;
    bus.shamt   = s;
    bus.data_in = d;
    @(posedge clk);
    #1;
    bus.cmd     = CMD_NOP;
    bus.shamt   = 5'd0;
    bus.data_in = 32'h0;
    @(negedge clk);
  endtask

  task automatic shift(input logic [2:0] c, input logic [4:0] s, input logic [31:0] req);
    exp_t e;
    e.data        = req;
    e.busy_cycles = int'(s);
    exp_q.push_back(e);
    send(c, s, 32'h0);
  endtask

  // Returns at the negedge where done is high, or flags a timeout.
  task automatic wait_done(input string name);
    int n;
    n = 0;
    while (bus.done !== 1'b1 && n < 100) begin
      @(negedge clk);
      n++;
    end
    if (bus.done !== 1'b1) begin
      checks++;
      errors++;
      $display("FAIL %s_timeout actual=no done required=done within 100", name);
    end
  endtask

  initial begin
    bus.cmd     = CMD_NOP;
    bus.shamt   = 5'd0;
    bus.data_in = 32'h0;
    reset       = 1'b1;
    repeat (3) @(posedge clk);
    @(negedge clk);
    check("reset_data", bus.data_out, 32'h0);
    check("reset_busy", 32'(bus.busy), 32'h0);
    check("reset_done", 32'(bus.done), 32'h0);
    reset = 1'b0;
    @(negedge clk);

    // LOAD then SLL 4
    send(CMD_LOAD, 5'd0, 32'h0000_00F0);
    check("load_f0", bus.data_out, 32'h0000_00F0);
    check("load_no_busy", 32'(bus.busy), 32'h0);
    check("load_no_done", 32'(bus.done), 32'h0);
    shift(CMD_SLL, 5'd4, 32'h0000_0F00);
    wait_done("sll4");
    @(negedge clk);
    check("done_one_cycle", 32'(bus.done), 32'h0);

    // SRA 31 and SRL 31 of the sign bit
    send(CMD_LOAD, 5'd0, 32'h8000_0000);
    shift(CMD_SRA, 5'd31, 32'hFFFF_FFFF);
    wait_done("sra31");
    send(CMD_LOAD, 5'd0, 32'h8000_0000);
    shift(CMD_SRL, 5'd31, 32'h0000_0001);
    wait_done("srl31");

    // LUI path
    send(CMD_LOAD, 5'd0, 32'h0000_ABCD);
    shift(CMD_SLL, 5'd16, 32'hABCD_0000);
    wait_done("lui");

    // Zero-length shift: done right after E0, busy never set
    send(CMD_LOAD, 5'd0, 32'h1234_5678);
    shift(CMD_SLL, 5'd0, 32'h1234_5678);
    check("n0_done_next", 32'(bus.done), 32'h1);
    wait_done("sll0");

    // Positive SRA fills with zeros
    send(CMD_LOAD, 5'd0, 32'h7000_0000);
    shift(CMD_SRA, 5'd4, 32'h0700_0000);
    wait_done("sra4");

    // Commands during busy are dropped; LOAD in the done cycle is taken
    send(CMD_LOAD, 5'd0, 32'h0000_0001);
    shift(CMD_SLL, 5'd8, 32'h0000_0100);
    send(CMD_LOAD, 5'd0, 32'hDEAD_BEEF);
    send(3'b111, 5'd3, 32'hDEAD_BEEF);
    wait_done("sll8");
    send(CMD_LOAD, 5'd0, 32'hCAFE_F00D);
    check("load_in_done", bus.data_out, 32'hCAFE_F00D);

    // Back-to-back shifts, second accepted in the done cycle
    send(CMD_LOAD, 5'd0, 32'h0000_0003);
    shift(CMD_SLL, 5'd1, 32'h0000_0006);
    wait_done("b2b_a");
    shift(CMD_SRL, 5'd1, 32'h0000_0003);
    wait_done("b2b_b");

    // Reset in the middle of SRL 10
    send(CMD_LOAD, 5'd0, 32'hFFFF_0000);
    send(CMD_SRL, 5'd10, 32'h0);
    @(negedge clk);
    @(negedge clk);
    reset = 1'b1;
    @(posedge clk);
    #1;
    check("rst_mid_data", bus.data_out, 32'h0);
    check("rst_mid_busy", 32'(bus.busy), 32'h0);
    check("rst_mid_done", 32'(bus.done), 32'h0);
    @(negedge clk);
    reset = 1'b0;
    repeat (15) @(negedge clk);
    check("rst_idle_busy", 32'(bus.busy), 32'h0);
    check("rst_idle_data", bus.data_out, 32'h0);

    check("queue_empty", 32'(exp_q.size()), 32'h0);
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
